// File: rtl/aso_peak_detector.sv
// Adaptive-threshold QRS peak detector on the Q2.10 ASO slope stream.
// Optional SEARCH-state threshold decay: define ASO_PD_TIMEOUT_EN.
module aso_peak_detector #(
  parameter int INIT_PK   = 512,
  parameter int THR_MIN   = 64,
  parameter int ALPHA_SH  = 3,
  parameter int REFRACT   = 50,
  parameter int MAX_WIDTH = 40,
  parameter int RR_W      = 12,
  parameter int TIMEOUT   = 400
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [11:0]      p,
  input  logic                    p_valid,
  output logic                    peak_valid,
  output logic signed [11:0]      peak_amp,
  output logic        [RR_W-1:0]  rr,
  output logic signed [11:0]      thr
);

  localparam int WW = $clog2(MAX_WIDTH + 1);
  localparam int RW = $clog2(REFRACT + 1);
  localparam logic signed [11:0] PK_INIT   = 12'(INIT_PK);
  localparam logic signed [11:0] THR_FLOOR = 12'(THR_MIN);
  localparam logic [WW-1:0]      WIDTH_LAST = WW'(MAX_WIDTH - 1);
  localparam logic [RW-1:0]      REF_LAST   = RW'(REFRACT - 1);

  typedef enum logic [1:0] {ST_SEARCH, ST_ABOVE, ST_REFRACT} state_t;

  function automatic logic signed [11:0] thr_of(input logic signed [11:0] pk);
    logic signed [11:0] half;
    half = pk >>> 1;
    return (half > THR_FLOOR) ? half : THR_FLOOR;
  endfunction

  state_t                 state_q, state_d;
  logic signed [11:0]     max_q, max_d;
  logic [WW-1:0]          width_q, width_d;
  logic [RW-1:0]          ref_q, ref_d;
  logic [RR_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic signed [11:0]     pk_q, pk_d;
  logic signed [11:0]     thr_q, thr_d;
  logic signed [11:0]     amp_q, amp_d;
  logic [RR_W-1:0]        rr_q, rr_d;
  logic                   pv_q, pv_d;
  logic signed [11:0]     pc, det_amp, pk_sh, amp_sh;
  logic signed [12:0]     pk_sum;
  logic                   det;
`ifdef ASO_PD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0]          to_q, to_d;
`endif

  assign pc = p[11] ? '0 : p;

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    width_d = width_q;
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    pk_d    = pk_q;
    thr_d   = thr_q;
    amp_d   = amp_q;
    rr_d    = rr_q;
    pv_d    = 1'b0;
    det     = 1'b0;
    det_amp = max_q;
    pk_sh   = '0;
    amp_sh  = '0;
    pk_sum  = '0;
`ifdef ASO_PD_TIMEOUT_EN
    to_d    = to_q;
`endif
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    if (p_valid) begin
      cnt_d = cnt_inc;
      unique case (state_q)
        ST_SEARCH: begin
          if (pc > thr_q) begin
            state_d = ST_ABOVE;
            max_d   = pc;
            width_d = WW'(1);
          end
`ifdef ASO_PD_TIMEOUT_EN
          else if (to_q == TO_LAST) begin
            to_d  = '0;
            pk_d  = pk_q >>> 1;
            thr_d = thr_of(pk_d);
          end else begin
            to_d = to_q + 1'b1;
          end
`endif
        end
        ST_ABOVE: begin
          // width_q counts earlier ABOVE samples; force when this one is the MAX_WIDTH-th
          if (pc <= thr_q) begin
            det = 1'b1;
          end else if (width_q == WIDTH_LAST) begin
            det     = 1'b1;
            det_amp = (pc > max_q) ? pc : max_q;
          end else begin
            max_d   = (pc > max_q) ? pc : max_q;
            width_d = width_q + 1'b1;
          end
        end
        ST_REFRACT: begin
          if (ref_q == REF_LAST) begin
            state_d = ST_SEARCH;
            ref_d   = '0;
`ifdef ASO_PD_TIMEOUT_EN
            to_d    = '0;
`endif
          end else begin
            ref_d = ref_q + 1'b1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
      if (det) begin
        state_d = ST_REFRACT;
        ref_d   = '0;
        width_d = '0;
        pv_d    = 1'b1;
        amp_d   = det_amp;
        rr_d    = cnt_inc;
        cnt_d   = '0;
        pk_sh   = pk_q >>> ALPHA_SH;
        amp_sh  = det_amp >>> ALPHA_SH;
        pk_sum  = {pk_q[11], pk_q} - {pk_sh[11], pk_sh} + {amp_sh[11], amp_sh};
        if (pk_sum[12] != pk_sum[11]) pk_d = pk_sum[12] ? 12'sh800 : 12'sh7FF;
        else                          pk_d = pk_sum[11:0];
        thr_d = thr_of(pk_d);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SEARCH;
      max_q   <= '0;
      width_q <= '0;
      ref_q   <= '0;
      cnt_q   <= '0;
      pk_q    <= PK_INIT;
      thr_q   <= thr_of(PK_INIT);
      amp_q   <= '0;
      rr_q    <= '0;
      pv_q    <= 1'b0;
`ifdef ASO_PD_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      width_q <= width_d;
      ref_q   <= ref_d;
      cnt_q   <= cnt_d;
      pk_q    <= pk_d;
      thr_q   <= thr_d;
      amp_q   <= amp_d;
      rr_q    <= rr_d;
      pv_q    <= pv_d;
`ifdef ASO_PD_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign peak_valid = pv_q;
  assign peak_amp   = amp_q;
  assign rr         = rr_q;
  assign thr        = thr_q;

endmodule

// File: tb/tb_aso_peak_detector.sv
// Randomized and directed bench for aso_peak_detector against a sample-level reference model.
module tb_aso_peak_detector;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [11:0] p = '0;
  logic               p_valid = 1'b0;
  logic               peak_valid;
  logic signed [11:0] peak_amp;
  logic [11:0]        rr;
  logic signed [11:0] thr;

  int n_checks = 0;
  int n_errors = 0;

  aso_peak_detector #(.RR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .p(p), .p_valid(p_valid),
    .peak_valid(peak_valid), .peak_amp(peak_amp), .rr(rr), .thr(thr)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = hunting, 1 = inside a peak, 2 = dead time
  int m_phase, m_pk, m_thr, m_since, m_nin, m_best, m_dead, m_idle;
  int e_pv, e_amp, e_rr, e_thr;

  function automatic int floor_thr(input int pk);
    return (pk / 2 > 64) ? pk / 2 : 64;
  endfunction

  task automatic m_reset();
    m_phase = 0; m_pk = 512; m_thr = floor_thr(512);
    m_since = 0; m_nin = 0; m_best = 0; m_dead = 0; m_idle = 0;
    e_pv = 0; e_amp = 0; e_rr = 0; e_thr = m_thr;
  endtask

  task automatic m_step(input bit v, input int raw);
    int x, amp, np;
    bit hit;
    e_pv = 0;
    if (!v) return;
    x = (raw < 0) ? 0 : raw;
    m_since = (m_since + 1 > 4095) ? 4095 : m_since + 1;
    hit = 0;
    amp = 0;
    if (m_phase == 0) begin
      if (x > m_thr) begin
        m_phase = 1; m_nin = 1; m_best = x;
      end else begin
`ifdef ASO_PD_TIMEOUT_EN
        m_idle++;
        if (m_idle == 400) begin
          m_idle = 0; m_pk = m_pk / 2; m_thr = floor_thr(m_pk);
        end
`endif
      end
    end else if (m_phase == 1) begin
      if (x <= m_thr) begin
        hit = 1; amp = m_best;
      end else if (m_nin + 1 == 40) begin
        hit = 1; amp = (x > m_best) ? x : m_best;
      end else begin
        m_nin++; if (x > m_best) m_best = x;
      end
    end else begin
      m_dead++;
      if (m_dead == 50) begin
        m_phase = 0; m_idle = 0;
      end
    end
    if (hit) begin
      e_pv = 1; e_amp = amp; e_rr = m_since; m_since = 0;
      np = m_pk - m_pk / 8 + amp / 8;
      m_pk = (np > 2047) ? 2047 : np;
      m_thr = floor_thr(m_pk);
      m_phase = 2; m_dead = 0;
    end
    e_thr = m_thr;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pv"},  int'(peak_valid), e_pv);
    check({tag, ".amp"}, int'(peak_amp),   e_amp);
    check({tag, ".rr"},  int'(rr),         e_rr);
    check({tag, ".thr"}, int'(thr),        e_thr);
  endtask

  task automatic step(input bit v, input int val, input string tag);
    @(negedge clk);
    p_valid = v;
    p = 12'(val);
    @(posedge clk);
    m_step(v, val);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    p_valid = 1'b0;
    #2;
    m_reset();
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int seq2[5];
    int seq5[5];
    int v, len, h;
    seq2 = '{0, 300, 600, 400, 100};
    seq5 = '{-500, 300, 600, 400, 100};
    m_reset();

    // 1: reset and idle
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 0, "idle");

    // 2: basic peak
    for (int i = 0; i < 5; i++) step(1'b1, seq2[i], "t2");
    check("t2_pv", int'(peak_valid), 1);
    check("t2_amp", int'(peak_amp), 600);
    check("t2_rr", int'(rr), 5);
    check("t2_thr", int'(thr), 261);
    step(1'b0, 0, "t2_after");
    check("t2_pulse", int'(peak_valid), 0);

    // 3: refractory masks large samples
    for (int i = 0; i < 50; i++) step(1'b1, 800, "t3_refr");
    step(1'b1, 801, "t3");
    step(1'b1, 200, "t3");
    check("t3_amp", int'(peak_amp), 801);
    check("t3_rr", int'(rr), 52);

    // 4: forced detection at max width
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 300, "t4");
    check("t4_pv", int'(peak_valid), 1);
    check("t4_amp", int'(peak_amp), 300);
    check("t4_rr", int'(rr), 40);

    // 5: gaps and negative samples
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq5[i], "t5");
      if (i < 4) for (int g = 0; g < 3; g++) step(1'b0, 1500, "t5_gap");
    end
    check("t5_amp", int'(peak_amp), 600);
    check("t5_rr", int'(rr), 5);
    check("t5_thr", int'(thr), 261);

    // threshold boundary: p == thr stays in SEARCH
    do_reset();
    step(1'b1, 256, "eq");
    step(1'b1, 100, "eq");
    check("eq_nopk", int'(peak_valid), 0);

    // 6: reset mid-peak
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, seq2[i], "t6");
    do_reset();
    check("t6_thr", int'(thr), 256);
    step(1'b1, 0, "t6_post");
    check("t6_nopk", int'(peak_valid), 0);

`ifdef ASO_PD_TIMEOUT_EN
    do_reset();
    for (int i = 0; i < 400; i++) step(1'b1, 0, "to1");
    check("to_thr1", int'(thr), 128);
    for (int i = 0; i < 400; i++) step(1'b1, 0, "to2");
    check("to_thr2", int'(thr), 64);
    for (int i = 0; i < 400; i++) step(1'b1, 0, "to3");
    check("to_thr3", int'(thr), 64);
`endif

    // RR saturation
    do_reset();
    for (int i = 0; i < 4200; i++) step(1'b1, 0, "sat");
    step(1'b1, 1000, "sat");
    step(1'b1, 0, "sat");
    check("sat_rr", int'(rr), 4095);

    // Random beats: quiet stretch, then a burst, with random p_valid gaps
    do_reset();
    for (int b = 0; b < 40; b++) begin
      len = int'($urandom_range(10, 150));
      for (int i = 0; i < len; i++) begin
        v = int'($urandom_range(0, 500)) - 300;
        step($urandom_range(0, 9) < 8, v, "rnd_q");
      end
      len = int'($urandom_range(1, 60));
      h = int'($urandom_range(150, 2000));
      for (int i = 0; i < len; i++) begin
        v = h - int'($urandom_range(0, 300));
        step($urandom_range(0, 9) < 8, v, "rnd_pk");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
